// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between instruction fetch and data ports.
// A per-transaction watchdog aborts hung accesses, returning a NOP to fetch and zero to data.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic busy, expired, done, grant_if, grant_d;

    // On contention the requester that did not win last time gets the memory.
    assign grant_d  = d_req && (!if_req || !last_d_q);
    assign grant_if = if_req && (!d_req || last_d_q);
    assign busy     = (state_q != IDLE);
    assign expired  = busy && (cnt_q == CNT_LAST);
    assign done     = busy && (mem_ack || expired);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_d_q      <= 1'b0;
            cnt_q         <= 16'd0;
            timeout_err_q <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            last_d_q      <= last_d_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d_d      = last_d_q;
        cnt_d         = 16'd0;
        timeout_err_d = timeout_err_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_if) begin
                    state_d    = BUSY_IF;
                    last_d_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                    // An ack in the final allowed cycle still counts as a normal completion.
                    if (!mem_ack) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req     = busy;
        mem_we      = mem_we_q;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        timeout_err = timeout_err_q;
        if_ready    = done && (state_q == BUSY_IF);
        d_ready     = done && (state_q == BUSY_D);
        if_rdata    = 32'd0;
        d_rdata     = 32'd0;
        if (if_ready) begin
            if_rdata = mem_ack ? mem_rdata : NOP_INST;
        end
        if (d_ready) begin
            d_rdata = mem_ack ? mem_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, timeout_err;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: acks on the ack_at-th cycle of each mem_req window.
    int          hi_cnt = 0;
    int          ack_at = 1;
    logic        resp_en = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] resp_data = 32'd0;

    always @(posedge clk) begin
        #2;
        if (mem_req) hi_cnt++;
        else hi_cnt = 0;
        mem_ack   = force_ack || (resp_en && mem_req && hi_cnt == ack_at);
        mem_rdata = mem_ack ? resp_data : 32'd0;
    end

    // Model: owner 0 = none, 1 = fetch, 2 = data; age = mem_req cycles already spent.
    int          m_owner = 0, m_age = 0, m_last = 1, m_grant = 0;
    logic        m_err = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_age = 0; m_last = 1; m_err = 1'b0;
            m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
        end else if (m_owner == 0) begin
            m_grant = 0;
            if (if_req && d_req) m_grant = (m_last == 2) ? 1 : 2;
            else if (if_req)     m_grant = 1;
            else if (d_req)      m_grant = 2;
            if (m_grant == 1) begin
                m_addr = if_addr; m_we = 1'b0;
            end else if (m_grant == 2) begin
                m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
            end
            if (m_grant != 0) begin
                m_owner = m_grant; m_last = m_grant; m_age = 0;
            end
        end else if (mem_ack) begin
            m_owner = 0;
        end else if (m_age + 1 >= TO) begin
            m_owner = 0; m_err = 1'b1;
        end else begin
            m_age++;
        end
    end

    // Per-cycle comparison and observation log.
    logic        e_busy, e_fin;
    logic [31:0] e_ifr, e_dr;
    int          win_cnt = 0, last_win = 0, idle_run = 0, cap_win = 0;
    int          if_pulses = 0, d_pulses = 0, we_cnt = 0;
    logic [31:0] cap_if_rdata = 32'd0, cap_d_rdata = 32'd0, cap_addr = 32'd0, cap_wdata = 32'd0;
    logic        cap_we = 1'b0;
    int          order[$];
    int          gaps[$];

    always @(negedge clk) begin
        e_busy = (m_owner != 0);
        e_fin  = e_busy && (mem_ack || m_age + 1 >= TO);
        e_ifr  = (e_fin && m_owner == 1) ? (mem_ack ? mem_rdata : NOP) : 32'd0;
        e_dr   = (e_fin && m_owner == 2) ? (mem_ack ? mem_rdata : 32'd0) : 32'd0;
        chk("mem_req", 32'(mem_req), 32'(e_busy));
        chk("if_ready", 32'(if_ready), 32'(e_fin && m_owner == 1));
        chk("d_ready", 32'(d_ready), 32'(e_fin && m_owner == 2));
        chk("if_rdata", if_rdata, e_ifr);
        chk("d_rdata", d_rdata, e_dr);
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        if (e_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (mem_req) begin
            if (win_cnt == 0) begin
                gaps.push_back(idle_run);
                idle_run = 0;
            end
            win_cnt++;
            if (mem_we) we_cnt++;
        end else begin
            if (win_cnt > 0) last_win = win_cnt;
            win_cnt = 0;
            idle_run++;
        end
        if (if_ready) begin
            if_pulses++; cap_if_rdata = if_rdata; cap_win = win_cnt; order.push_back(1);
        end
        if (d_ready) begin
            d_pulses++; cap_d_rdata = d_rdata; cap_win = win_cnt; order.push_back(2);
            cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input bit is_d, input int bound);
        int  start;
        bit  ok;
        start = is_d ? d_pulses : if_pulses;
        ok = 1'b0;
        for (int n = 0; n < bound && !ok; n++) begin
            sample();
            ok = ((is_d ? d_pulses : if_pulses) > start);
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    function automatic int at_or(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    int base_if, base_d, base_we, ob, gb;

    initial begin
        cyc(3);
        rst = 1'b0;
        sample();
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset timeout_err", 32'(timeout_err), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);

        // Fetch only, ack on the 4th mem_req cycle.
        resp_en = 1'b1; ack_at = 4; resp_data = 32'h0050_0093;
        base_if = if_pulses; base_we = we_cnt;
        cyc(1);
        if_req = 1'b1; if_addr = 32'h100;
        wait_ready("fetch ready", 1'b0, 20);
        chk("fetch if_rdata", cap_if_rdata, 32'h0050_0093);
        chk("fetch window", 32'(cap_win), 32'd4);
        cyc(1);
        if_req = 1'b0;
        cyc(3);
        chk("fetch pulses", 32'(if_pulses - base_if), 32'd1);
        chk("fetch mem_we", 32'(we_cnt - base_we), 32'd0);
        chk("fetch no err", 32'(timeout_err), 32'd0);

        // Store only, immediate ack.
        ack_at = 1; resp_data = 32'h0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        wait_ready("store ready", 1'b1, 20);
        chk("store mem_addr", cap_addr, 32'h2000);
        chk("store mem_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("store mem_we", 32'(cap_we), 32'd1);
        chk("store window", 32'(cap_win), 32'd1);
        cyc(1);
        d_req = 1'b0; d_we = 1'b0;
        cyc(2);

        // Continuous contention from a fresh reset: D, IF, D, IF.
        do_reset();
        ack_at = 2; resp_data = 32'h1111_2222;
        ob = order.size(); gb = gaps.size();
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_addr = 32'h500; d_we = 1'b0;
        for (int n = 0; n < 60 && order.size() < ob + 4; n++) sample();
        cyc(1);
        if_req = 1'b0; d_req = 1'b0;
        cyc(3);
        chk("order 0", 32'(at_or(order, ob)), 32'd2);
        chk("order 1", 32'(at_or(order, ob + 1)), 32'd1);
        chk("order 2", 32'(at_or(order, ob + 2)), 32'd2);
        chk("order 3", 32'(at_or(order, ob + 3)), 32'd1);
        chk("order count", 32'(order.size() - ob), 32'd4);
        for (int k = 1; k < 4; k++) chk("bubble", 32'(at_or(gaps, gb + k)), 32'd1);

        // Watchdog abort on a fetch with no ack.
        do_reset();
        resp_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h300;
        wait_ready("abort ready", 1'b0, 20);
        chk("abort if_rdata", cap_if_rdata, 32'h0000_0013);
        chk("abort window", 32'(cap_win), 32'd4);
        cyc(1);
        if_req = 1'b0;
        cyc(3);
        chk("abort last_win", 32'(last_win), 32'd4);
        chk("abort sticky err", 32'(timeout_err), 32'd1);

        // Ack lands in the final allowed cycle: normal completion.
        do_reset();
        chk("err cleared", 32'(timeout_err), 32'd0);
        resp_en = 1'b1; ack_at = 4; resp_data = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h304;
        wait_ready("tie ready", 1'b0, 20);
        chk("tie if_rdata", cap_if_rdata, 32'h1234_5678);
        chk("tie window", 32'(cap_win), 32'd4);
        cyc(1);
        if_req = 1'b0;
        cyc(2);
        chk("tie no err", 32'(timeout_err), 32'd0);

        // Reset in the middle of a data transaction.
        do_reset();
        resp_en = 1'b0;
        base_d = d_pulses;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        cyc(3);
        chk("busy before rst", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst drops mem_req", 32'(mem_req), 32'd0);
        d_req = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        force_ack = 1'b1;
        cyc(1);
        force_ack = 1'b0;
        cyc(1);
        chk("rst no d_ready", 32'(d_pulses - base_d), 32'd0);
        resp_en = 1'b1; ack_at = 2; resp_data = 32'hCAFE_0001;
        if_req = 1'b1; if_addr = 32'h500;
        wait_ready("post-rst fetch", 1'b0, 20);
        chk("post-rst if_rdata", cap_if_rdata, 32'hCAFE_0001);
        cyc(1);
        if_req = 1'b0;
        cyc(2);

        // Spurious ack while idle.
        base_if = if_pulses; base_d = d_pulses;
        force_ack = 1'b1; resp_data = 32'h5555_AAAA;
        sample();
        chk("spurious if_ready", 32'(if_ready), 32'd0);
        chk("spurious d_ready", 32'(d_ready), 32'd0);
        cyc(1);
        force_ack = 1'b0;
        sample();
        chk("spurious mem_req", 32'(mem_req), 32'd0);
        chk("spurious pulses", 32'(if_pulses - base_if + d_pulses - base_d), 32'd0);

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
